i2c_reg_slave: RTL and testbench

- Pure-RTL I2C slave exposing a parametrised bank of 8-bit registers to an external I2C master over open-drain SCL/SDA.
- Successor to the Qsys-wrapped slave: configurable device address, register count and input filtering; adds a register-pointer protocol, auto-increment with wrap, repeated START and per-write strobes.
- Sits beside the Nios I2C master on the PMOD pins. The top level converts the *_oe outputs to tri-state (oe=1 drives 0, otherwise Z).

---
 rtl/i2c_reg_slave.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave that exposes a bank of 8-bit registers.
// The first byte after a write address sets the register pointer. Further
// bytes are written at the pointer and the pointer auto-increments with wrap.
// Reads start at the pointer and auto-increment the same way.
// wr_stb is a one-clock pulse. There is no back-pressure: wr_idx and the
// updated reg_q are valid in the cycle where wr_stb is high.
module i2c_reg_slave #(
   parameter logic [6:0] I2C_ADDR   = 7'h50,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3,
   parameter logic [7:0] RESET_VAL  = 8'h00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  scl_oe,
   output logic                  sda_oe,
   output logic [NUM_REGS*8-1:0] reg_q,
   output logic                  wr_stb,
   output logic [7:0]            wr_idx,
   output logic                  busy,
   output logic [3:0]            dbg_state
);

   localparam int PW = $clog2(NUM_REGS);
   localparam int CW = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      PTR       = 4'd3,
      PTR_ACK   = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RDATA_ACK = 4'd8,
      WAIT_STOP = 4'd9
   } state_t;

   state_t          state, state_n;
   logic [1:0]      scl_sync, sda_sync;
   logic [CW-1:0]   scl_cnt, sda_cnt;
   logic            scl_f, sda_f, scl_d, sda_d;
   logic            scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]      bit_cnt, cnt_n;
   logic [7:0]      shreg, sh_n;
   logic            oe_n, stb_n, busy_n, reg_we, do_load;
   logic [7:0]      idx_n;
   logic [PW-1:0]   ptr, ptr_n, ptr_inc;
   logic [7:0]      regs [NUM_REGS];
   logic [7:0]      rd_byte;

   // No clock stretching: SCL is never driven.
   assign scl_oe    = 1'b0;
   assign dbg_state = state;

   // Two-flop synchronisers; the idle bus level is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
      end
   end

   // SCL glitch filter: the level changes only after FILTER_LEN differing samples in a row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_f   <= 1'b1;
         scl_cnt <= '0;
      end else if (scl_sync[1] == scl_f) begin
         scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
         scl_f   <= scl_sync[1];
         scl_cnt <= '0;
      end else begin
         scl_cnt <= scl_cnt + 1'b1;
      end
   end

   // SDA glitch filter, same rule as SCL so both paths have equal latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sda_f   <= 1'b1;
         sda_cnt <= '0;
      end else if (sda_sync[1] == sda_f) begin
         sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
         sda_f   <= sda_sync[1];
         sda_cnt <= '0;
      end else begin
         sda_cnt <= sda_cnt + 1'b1;
      end
   end

   // Previous filtered levels for edge and START/STOP detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   assign scl_rise  =  scl_f & ~scl_d;
   assign scl_fall  = ~scl_f &  scl_d;
   assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
   assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

   assign ptr_inc = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
   assign rd_byte = regs[ptr];

   // FSM state and protocol datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         sda_oe  <= 1'b0;
         ptr     <= '0;
         wr_stb  <= 1'b0;
         wr_idx  <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         shreg   <= sh_n;
         sda_oe  <= oe_n;
         ptr     <= ptr_n;
         wr_stb  <= stb_n;
         wr_idx  <= idx_n;
         busy    <= busy_n;
      end
   end

   // Next-state logic: START/STOP take priority, otherwise act on filtered SCL edges.
   always_comb begin
      state_n = state;
      cnt_n   = bit_cnt;
      sh_n    = shreg;
      oe_n    = sda_oe;
      ptr_n   = ptr;
      stb_n   = 1'b0;
      idx_n   = wr_idx;
      busy_n  = busy;
      reg_we  = 1'b0;
      do_load = 1'b0;
      if (stop_det) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
         cnt_n   = '0;
      end else if (start_det) begin
         state_n = ADDR;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, PTR, WDATA: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  sh_n  = {shreg[6:0], sda_f};
                  cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  cnt_n = '0;
                  if (state == ADDR) begin
                     // shreg[0] keeps the R/W bit through ADDR_ACK.
                     if (shreg[7:1] == I2C_ADDR) begin
                        oe_n    = 1'b1;
                        state_n = ADDR_ACK;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end else if (state == PTR) begin
                     if (int'(shreg) < NUM_REGS) begin
                        oe_n    = 1'b1;
                        ptr_n   = shreg[PW-1:0];
                        state_n = PTR_ACK;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end else begin
                     reg_we  = 1'b1;
                     stb_n   = 1'b1;
                     idx_n   = 8'(ptr);
                     ptr_n   = ptr_inc;
                     oe_n    = 1'b1;
                     state_n = WDATA_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (shreg[0]) begin
                     do_load = 1'b1;
                  end else begin
                     oe_n    = 1'b0;
                     state_n = PTR;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  state_n = WDATA;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n    = 1'b0;
                     state_n = RDATA_ACK;
                  end else begin
                     sh_n = {shreg[6:0], 1'b0};
                     oe_n = ~shreg[6];
                  end
               end
            end
            RDATA_ACK: begin
               // bit_cnt = 9 marks a master ACK waiting for the next falling edge.
               if (scl_rise) begin
                  if (sda_f) state_n = WAIT_STOP;
                  else       cnt_n   = 4'd9;
               end else if (scl_fall && bit_cnt == 4'd9) begin
                  do_load = 1'b1;
               end
            end
            WAIT_STOP: oe_n = 1'b0;
            default: begin
               state_n = IDLE;
               oe_n    = 1'b0;
            end
         endcase
         if (do_load) begin
            sh_n    = rd_byte;
            oe_n    = ~rd_byte[7];
            ptr_n   = ptr_inc;
            cnt_n   = '0;
            state_n = RDATA;
         end
      end
   end

   // Register bank, written with the received byte at the current pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (reg_we) begin
         regs[ptr] <= shreg;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
      assign reg_q[g*8 +: 8] = regs[g];
   end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed testbench for i2c_reg_slave acting as a bit-banged I2C master.
module tb_i2c_reg_slave;

   localparam int Q = 10;
   localparam int H = 20;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         scl_m = 1'b1;
   logic         sda_m = 1'b1;
   logic         sda_line;
   logic         scl_oe, sda_oe, wr_stb, busy;
   logic [127:0] reg_q;
   logic [7:0]   wr_idx;
   logic [3:0]   dbg_state;

   int n_checks = 0;
   int n_pass = 0;
   int data_oe_viol = 0;
   int oe_cnt = 0;
   logic [7:0] exp_regs [16];
   logic [7:0] wr_log[$];
   logic [7:0] exp_q[$];

   assign sda_line = sda_m & ~sda_oe;

   i2c_reg_slave #(
      .I2C_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(3), .RESET_VAL(8'h00)
   ) dut (
      .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .reg_q(reg_q), .wr_stb(wr_stb),
      .wr_idx(wr_idx), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // monitor: write strobes and any SDA drive, sampled on the falling clock edge
   always @(negedge clk) begin
      if (wr_stb) wr_log.push_back(wr_idx);
      if (sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] f;
      for (int i = 0; i < 16; i++) f[i*8 +: 8] = exp_regs[i];
      return f;
   endfunction

   task automatic check_log(input string tag);
      check({tag, "_cnt"}, wr_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < wr_log.size()) check({tag, "_idx"}, wr_log[i], exp_q[i]);
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // driver tasks
   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b, input logic glitch, output logic line, output logic oe);
      sda_m = b; tick(Q);
      scl_m = 1'b1; tick(H/2);
      line = sda_line;
      oe   = sda_oe;
      if (glitch) begin
         scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(4);
         sda_m = ~b;   tick(1); sda_m = b;    tick(6);
         check("glitch_state", dbg_state, 4'd5);
         check("glitch_busy", busy, 1'b1);
      end
      tick(H/2);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic glitch, output logic ack);
      logic line, oe;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], glitch && (i == 7), line, oe);
         if (oe) data_oe_viol++;
      end
      send_bit(1'b1, 1'b0, line, oe);
      ack = ~line;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic line, oe;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, 1'b0, line, oe);
         d = {d[6:0], line};
      end
      send_bit(nack, 1'b0, line, oe);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      logic       line, oe;
      logic [7:0] addr_w;

      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

      // reset state
      tick(3);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_scl_oe", scl_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_stb", wr_stb, 1'b0);
      check("rst_wr_idx", wr_idx, 8'h00);
      check("rst_regs", reg_q, model_flat());
      check("rst_state", dbg_state, 4'd0);
      reset = 1'b0;
      tick(5);

      // single write: reg3 = 5A
      data_oe_viol = 0;
      i2c_start();
      check("busy_start", busy, 1'b1);
      write_byte(8'hA0, 1'b0, ack); check("w1_addr_ack", ack, 1'b1);
      write_byte(8'h03, 1'b0, ack); check("w1_ptr_ack", ack, 1'b1);
      write_byte(8'h5A, 1'b0, ack); check("w1_data_ack", ack, 1'b1);
      i2c_stop();
      exp_regs[3] = 8'h5A;
      exp_q.push_back(8'd3);
      check("w1_reg3", reg_q[31:24], 8'h5A);
      check("w1_regs", reg_q, model_flat());
      check_log("w1_stb");
      check("w1_no_data_drive", data_oe_viol, 0);
      check("w1_busy_stop", busy, 1'b0);
      check("w1_sda_released", sda_oe, 1'b0);

      // burst write wrapping from reg15 to reg0
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h0F, 1'b0, ack);
      write_byte(8'h11, 1'b0, ack); check("wrap_ack1", ack, 1'b1);
      write_byte(8'h22, 1'b0, ack); check("wrap_ack2", ack, 1'b1);
      i2c_stop();
      exp_regs[15] = 8'h11;
      exp_regs[0]  = 8'h22;
      exp_q.push_back(8'd15);
      exp_q.push_back(8'd0);
      check("wrap_regs", reg_q, model_flat());
      check_log("wrap_stb");

      // load reg2/reg3 for the read tests
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h02, 1'b0, ack);
      write_byte(8'hC3, 1'b0, ack);
      write_byte(8'h3C, 1'b0, ack);
      i2c_stop();
      exp_regs[2] = 8'hC3;
      exp_regs[3] = 8'h3C;
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd3);
      check("ld_regs", reg_q, model_flat());
      check_log("ld_stb");

      // combined read with repeated START
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h02, 1'b0, ack);
      i2c_start();
      write_byte(8'hA1, 1'b0, ack); check("rd_addr_ack", ack, 1'b1);
      read_byte(1'b0, d); check("rd_byte0", d, 8'hC3);
      read_byte(1'b1, d); check("rd_byte1", d, 8'h3C);
      tick(Q);
      check("rd_nack_release", sda_oe, 1'b0);
      check("rd_wait_stop", dbg_state, 4'd9);
      i2c_stop();
      check("rd_busy_stop", busy, 1'b0);
      check_log("rd_stb");

      // pointer survives STOP
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h02, 1'b0, ack);
      i2c_stop();
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      read_byte(1'b1, d); check("ptr_keep_read", d, 8'hC3);
      i2c_stop();

      // address mismatch: SDA never driven
      oe_cnt = 0;
      i2c_start();
      write_byte(8'hB0, 1'b0, ack); check("mis_addr_nack", ack, 1'b0);
      write_byte(8'h55, 1'b0, ack); check("mis_data_nack", ack, 1'b0);
      i2c_stop();
      check("mis_no_drive", oe_cnt, 0);
      check_log("mis_stb");

      // bad pointer: NACK, no write, pointer unchanged (still 3)
      i2c_start();
      write_byte(8'hA0, 1'b0, ack); check("bad_addr_ack", ack, 1'b1);
      write_byte(8'h20, 1'b0, ack); check("bad_ptr_nack", ack, 1'b0);
      write_byte(8'h77, 1'b0, ack); check("bad_data_nack", ack, 1'b0);
      i2c_stop();
      check("bad_regs", reg_q, model_flat());
      check_log("bad_stb");
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      read_byte(1'b1, d); check("bad_ptr_kept", d, 8'h3C);
      i2c_stop();

      // glitches on SCL and SDA while SCL is high
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      write_byte(8'h05, 1'b0, ack);
      write_byte(8'h5A, 1'b1, ack); check("glitch_ack", ack, 1'b1);
      i2c_stop();
      exp_regs[5] = 8'h5A;
      exp_q.push_back(8'd5);
      check("glitch_regs", reg_q, model_flat());
      check_log("glitch_stb");

      // reset while the slave is driving the address ACK
      i2c_start();
      addr_w = 8'hA0;
      for (int i = 7; i >= 0; i--) send_bit(addr_w[i], 1'b0, line, oe);
      check("mid_ack_driven", sda_oe, 1'b1);
      #3 reset = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      check("mid_rst_sda_oe", sda_oe, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_regs", reg_q, model_flat());
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(10);
      check("mid_rst_state", dbg_state, 4'd0);
      wr_log.delete();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
